score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Two-player score keeper: edge-detected point inputs, game FSM, winner and game-over pulse.
// Optional win-by-two rule (DEUCE/ADV1/ADV2 states) enabled by defining SCORE_WIN_BY_TWO_EN.
`timescale 1ns/1ps
module score_keeper #(
    parameter int unsigned SCORE_W   = 3,
    parameter int unsigned WIN_SCORE = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               point1,
    input  logic               point2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               playing,
    output logic               winner,
    output logic               game_over,
    output logic               adv1,
    output logic               adv2
);

    localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] LAST_S = SCORE_W'(WIN_SCORE - 1);
    localparam logic [SCORE_W-1:0] ONE_S  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] ZERO_S = '0;

`ifdef SCORE_WIN_BY_TWO_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        DEUCE = 3'd2,
        ADV1  = 3'd3,
        ADV2  = 3'd4,
        OVER  = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        OVER  = 3'd5
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               p1_q, p1_d;
    logic               p2_q, p2_d;
    logic               winner_q, winner_d;
    logic               game_over_q, game_over_d;
    logic               playing_q, playing_d;
    logic               adv1_q, adv1_d;
    logic               adv2_q, adv2_d;

    logic               edge1_c, edge2_c;
    logic               solo1_c, solo2_c;
    logic [SCORE_W-1:0] inc1_c, inc2_c;

    // Point edges; a simultaneous pair cancels out
    always_comb begin
        edge1_c = point1 & ~p1_q;
        edge2_c = point2 & ~p2_q;
        solo1_c = edge1_c & ~edge2_c;
        solo2_c = edge2_c & ~edge1_c;
        inc1_c  = score1_q + ONE_S;
        inc2_c  = score2_q + ONE_S;
    end

    // Next-state, score and registered-output logic
    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        winner_d    = winner_q;
        p1_d        = point1;
        p2_d        = point2;
        game_over_d = 1'b0;
        playing_d   = 1'b0;
        adv1_d      = 1'b0;
        adv2_d      = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d  = PLAY;
                    score1_d = ZERO_S;
                    score2_d = ZERO_S;
                end
            end
            PLAY: begin
                if (solo1_c) begin
                    score1_d = inc1_c;
                    if (inc1_c == WIN_S) begin
                        state_d  = OVER;
                        winner_d = 1'b0;
                    end
`ifdef SCORE_WIN_BY_TWO_EN
                    else if (inc1_c == LAST_S && score2_q == LAST_S) begin
                        state_d = DEUCE;
                    end
`endif
                end else if (solo2_c) begin
                    score2_d = inc2_c;
                    if (inc2_c == WIN_S) begin
                        state_d  = OVER;
                        winner_d = 1'b1;
                    end
`ifdef SCORE_WIN_BY_TWO_EN
                    else if (inc2_c == LAST_S && score1_q == LAST_S) begin
                        state_d = DEUCE;
                    end
`endif
                end
            end
`ifdef SCORE_WIN_BY_TWO_EN
            DEUCE: begin
                if (solo1_c) begin
                    state_d = ADV1;
                end else if (solo2_c) begin
                    state_d = ADV2;
                end
            end
            ADV1: begin
                if (solo1_c) begin
                    state_d  = OVER;
                    winner_d = 1'b0;
                end else if (solo2_c) begin
                    state_d = DEUCE;
                end
            end
            ADV2: begin
                if (solo2_c) begin
                    state_d  = OVER;
                    winner_d = 1'b1;
                end else if (solo1_c) begin
                    state_d = DEUCE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        game_over_d = (state_d == OVER) && (state_q != OVER);
        playing_d   = (state_d != IDLE) && (state_d != OVER);
`ifdef SCORE_WIN_BY_TWO_EN
        adv1_d      = (state_d == ADV1);
        adv2_d      = (state_d == ADV2);
`endif
    end

    // Edge registers reset high so a level held through reset never scores
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            score1_q    <= ZERO_S;
            score2_q    <= ZERO_S;
            p1_q        <= 1'b1;
            p2_q        <= 1'b1;
            winner_q    <= 1'b0;
            game_over_q <= 1'b0;
            playing_q   <= 1'b0;
            adv1_q      <= 1'b0;
            adv2_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            playing_q   <= playing_d;
            adv1_q      <= adv1_d;
            adv2_q      <= adv2_d;
        end
    end

    assign score1    = score1_q;
    assign score2    = score2_q;
    assign playing   = playing_q;
    assign winner    = winner_q;
    assign game_over = game_over_q;
    assign adv1      = adv1_q;
    assign adv2      = adv2_q;

endmodule
